// File: rtl/cond_check_stage.sv
// cond_check_stage: condition-code check between the decode latch and the
// execute-stage control mux. Evaluates the ARM condition field against PSR
// flags (or flags forwarded from the ALU), tracks flag-setting instructions
// still in flight, holds back condition-dependent instructions until their
// flags are known, and registers a pass/annul decision for execute.
//
// Optional build macro COND_STATS_EN: adds saturating Pass_cnt/Annul_cnt
// statistics outputs (CNT_W bits each). Undefined by default.
module cond_check_stage #(
  parameter int MAX_PENDING = 3,
  parameter int PEND_W      = 2
`ifdef COND_STATS_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [3:0]        In_cond,
  input  logic              In_s,
  input  logic              N,
  input  logic              Z,
  input  logic              C,
  input  logic              V,
  input  logic              Fwd_valid,
  input  logic              Fwd_N,
  input  logic              Fwd_Z,
  input  logic              Fwd_C,
  input  logic              Fwd_V,
  input  logic              Flag_wb,
  input  logic              Stall,
  output logic              Out_valid,
  output logic              Out_pass,
  output logic              Out_s,
  output logic [PEND_W-1:0] Pending
`ifdef COND_STATS_EN
  , output logic [CNT_W-1:0] Pass_cnt
  , output logic [CNT_W-1:0] Annul_cnt
`endif
);

  // ARM condition field evaluation against a flag set.
  function automatic logic cond_eval(input logic [3:0] cc, input logic n,
                                     input logic z, input logic c,
                                     input logic v);
    logic r;
    r = 1'b0;
    case (cc)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = c;
      4'b0011: r = !c;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = c & !z;
      4'b1001: r = !c | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

`ifdef COND_STATS_EN
  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (&x) ? x : x + CNT_W'(1);
  endfunction
`endif

  logic [PEND_W-1:0] pend_cnt;
  logic              vld_p1;
  logic              pass_p1;
  logic              s_p1;

  logic              use_fwd;
  logic              fn, fz, fc, fv;
  logic              cond_ok;
  logic              no_wait;
  logic              flag_hazard;
  logic              full;
  logic              ready;
  logic              accept;
  logic              pend_inc;
  logic              pend_dec;

  // Decode-side decision: flag source, hazard/full checks and accept.
  always_comb begin
    use_fwd     = (pend_cnt == PEND_W'(1)) && Fwd_valid;
    fn          = use_fwd ? Fwd_N : N;
    fz          = use_fwd ? Fwd_Z : Z;
    fc          = use_fwd ? Fwd_C : C;
    fv          = use_fwd ? Fwd_V : V;
    cond_ok     = cond_eval(In_cond, fn, fz, fc, fv);
    // AL and NV are flag-independent and never wait.
    no_wait     = (In_cond[3:1] == 3'b111);
    flag_hazard = (pend_cnt != '0) && !no_wait && !use_fwd;
    full        = (pend_cnt == PEND_W'(MAX_PENDING)) && In_s;
    ready       = !Stall && !flag_hazard && !full;
    accept      = In_valid && ready;
    // Only passed S instructions will actually write the PSR.
    pend_inc    = accept && In_s && cond_ok;
    pend_dec    = Flag_wb && (pend_cnt != '0);
  end

  assign In_ready = ready;

  // ---- stage p1: registered pass/annul decision for execute ----
  // Output register: loads a decision or a bubble unless stalled.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vld_p1  <= 1'b0;
      pass_p1 <= 1'b0;
      s_p1    <= 1'b0;
    end else if (!Stall) begin
      vld_p1  <= accept;
      pass_p1 <= accept && cond_ok;
      s_p1    <= accept && In_s && cond_ok;
    end
  end

  // In-flight flag-setter counter; write-back retires even during stall.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_cnt <= '0;
    end else if (pend_inc && !pend_dec) begin
      pend_cnt <= pend_cnt + PEND_W'(1);
    end else if (pend_dec && !pend_inc) begin
      pend_cnt <= pend_cnt - PEND_W'(1);
    end
  end

  assign Out_valid = vld_p1;
  assign Out_pass  = pass_p1;
  assign Out_s     = s_p1;
  assign Pending   = pend_cnt;

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] annul_cnt_q;

  // Statistics: accepted instructions split by pass/annul, saturating.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pass_cnt_q  <= '0;
      annul_cnt_q <= '0;
    end else if (accept) begin
      if (cond_ok) pass_cnt_q  <= sat_inc(pass_cnt_q);
      else         annul_cnt_q <= sat_inc(annul_cnt_q);
    end
  end

  assign Pass_cnt  = pass_cnt_q;
  assign Annul_cnt = annul_cnt_q;
`endif

endmodule

// File: tb/tb_cond_check_stage.sv
// Self-checking bench for cond_check_stage: directed scenarios followed by
// randomized traffic, all checked against a flag/condition model held here.
module tb_cond_check_stage;
  localparam int MAX_PENDING = 3;
  localparam int PEND_W      = 2;
  localparam int CNT_W       = 16;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset_n, In_valid, In_s, N, Z, C, V;
  logic       Fwd_valid, Fwd_N, Fwd_Z, Fwd_C, Fwd_V, Flag_wb, Stall;
  logic [3:0] In_cond;
  logic       In_ready, Out_valid, Out_pass, Out_s;
  logic [PEND_W-1:0] Pending;
`ifdef COND_STATS_EN
  logic [CNT_W-1:0] Pass_cnt, Annul_cnt;
`endif

  cond_check_stage #(.MAX_PENDING(MAX_PENDING), .PEND_W(PEND_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .In_valid(In_valid), .In_ready(In_ready),
    .In_cond(In_cond), .In_s(In_s), .N(N), .Z(Z), .C(C), .V(V),
    .Fwd_valid(Fwd_valid), .Fwd_N(Fwd_N), .Fwd_Z(Fwd_Z), .Fwd_C(Fwd_C),
    .Fwd_V(Fwd_V), .Flag_wb(Flag_wb), .Stall(Stall), .Out_valid(Out_valid),
    .Out_pass(Out_pass), .Out_s(Out_s), .Pending(Pending)
`ifdef COND_STATS_EN
    , .Pass_cnt(Pass_cnt), .Annul_cnt(Annul_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference state
  int m_pend;
  bit m_vld, m_pass, m_s;
  int m_pcnt, m_acnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ARM condition semantics by mnemonic.
  function automatic bit arm_cond(input logic [3:0] cc, input bit n,
                                  input bit z, input bit c, input bit v);
    bit ge;
    ge = (n == v);
    case (cc)
      0: return z;            // EQ
      1: return !z;           // NE
      2: return c;            // CS
      3: return !c;           // CC
      4: return n;            // MI
      5: return !n;           // PL
      6: return v;            // VS
      7: return !v;           // VC
      8: return c && !z;      // HI
      9: return !(c && !z);   // LS
      10: return ge;          // GE
      11: return !ge;         // LT
      12: return !z && ge;    // GT
      13: return !(!z && ge); // LE
      14: return 1'b1;        // AL
      default: return 1'b0;   // NV
    endcase
  endfunction

  task automatic model_reset();
    m_pend = 0; m_vld = 0; m_pass = 0; m_s = 0; m_pcnt = 0; m_acnt = 0;
  endtask

  task automatic idle();
    In_valid = 0; In_cond = 4'hE; In_s = 0; Fwd_valid = 0;
    Fwd_N = 0; Fwd_Z = 0; Fwd_C = 0; Fwd_V = 0; Flag_wb = 0; Stall = 0;
  endtask

  // One clock: check combinational outputs, predict, clock, check registers.
  task automatic tick();
    bit fwd, ok, waits, full, rdy, acc;
    int dec;
    #1;
    fwd   = (m_pend == 1) && Fwd_valid;
    ok    = fwd ? arm_cond(In_cond, Fwd_N, Fwd_Z, Fwd_C, Fwd_V)
                : arm_cond(In_cond, N, Z, C, V);
    waits = (m_pend > 0) && (In_cond < 14) && !fwd;
    full  = (m_pend == MAX_PENDING) && In_s;
    rdy   = !Stall && !waits && !full;
    chk("in_ready", {31'd0, In_ready}, {31'd0, rdy});
    acc = In_valid && rdy;
    if (!Stall) begin
      m_vld = acc; m_pass = acc && ok; m_s = acc && ok && In_s;
    end
    if (acc && ok && m_pcnt < 65535) m_pcnt++;
    if (acc && !ok && m_acnt < 65535) m_acnt++;
    dec = (Flag_wb && m_pend > 0) ? 1 : 0;
    m_pend = m_pend + ((acc && In_s && ok) ? 1 : 0) - dec;
    @(posedge Clk);
    #1;
    chk("out_valid", {31'd0, Out_valid}, {31'd0, m_vld});
    chk("out_pass", {31'd0, Out_pass}, {31'd0, m_pass});
    chk("out_s", {31'd0, Out_s}, {31'd0, m_s});
    chk("pending", {30'd0, Pending}, m_pend);
`ifdef COND_STATS_EN
    chk("pass_cnt", {16'd0, Pass_cnt}, m_pcnt);
    chk("annul_cnt", {16'd0, Annul_cnt}, m_acnt);
`endif
  endtask

  task automatic issue(input logic [3:0] cc, input logic s);
    In_valid = 1; In_cond = cc; In_s = s;
    tick();
    In_valid = 0;
  endtask

  int pc_before;

  initial begin
    idle();
    N = 0; Z = 0; C = 0; V = 0;
    Reset_n = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_out_valid", {31'd0, Out_valid}, 0);
    chk("rst_out_pass", {31'd0, Out_pass}, 0);
    chk("rst_out_s", {31'd0, Out_s}, 0);
    chk("rst_pending", {30'd0, Pending}, 0);
    Reset_n = 1;

    // EQ then NE against PSR Z=1
    Z = 1;
    issue(4'h0, 0);
    chk("eq_pass", {31'd0, Out_pass}, 1);
    issue(4'h1, 0);
    chk("ne_pass", {31'd0, Out_pass}, 0);
    chk("ne_valid", {31'd0, Out_valid}, 1);
    chk("eq_ne_pend", {30'd0, Pending}, 0);

    // ADDS then BEQ on forwarded Z
    Z = 0;
    issue(4'hE, 1);
    chk("adds_pend", {30'd0, Pending}, 1);
    Fwd_valid = 1; Fwd_Z = 1;
    In_valid = 1; In_cond = 4'h0; In_s = 0;
    #1 chk("beq_ready", {31'd0, In_ready}, 1);
    tick();
    idle();
    chk("beq_pass_fwd", {31'd0, Out_pass}, 1);

    // Pending=2, GT waits until write-back leaves one in flight with forwarding
    issue(4'hE, 1);
    chk("gt_pend2", {30'd0, Pending}, 2);
    Z = 1;
    In_valid = 1; In_cond = 4'hC; In_s = 0;
    tick();
    chk("gt_bubble", {31'd0, Out_valid}, 0);
    Flag_wb = 1;
    tick();
    chk("gt_bubble2", {31'd0, Out_valid}, 0);
    chk("gt_pend1", {30'd0, Pending}, 1);
    Flag_wb = 0; Fwd_valid = 1; Fwd_Z = 0; Fwd_N = 1; Fwd_V = 1;
    tick();
    idle();
    chk("gt_fwd_valid", {31'd0, Out_valid}, 1);
    chk("gt_fwd_pass", {31'd0, Out_pass}, 1);
    Z = 0;

    // Pending=3 blocks S instruction; simultaneous write-back frees a slot
    issue(4'hE, 1);
    issue(4'hE, 1);
    chk("full_pend3", {30'd0, Pending}, 3);
    In_valid = 1; In_cond = 4'hE; In_s = 1; Flag_wb = 1;
    #1 chk("full_ready", {31'd0, In_ready}, 0);
    tick();
    chk("full_pend2", {30'd0, Pending}, 2);
    Flag_wb = 0;
    tick();
    idle();
    chk("full_acc_pend3", {30'd0, Pending}, 3);
    Flag_wb = 1;
    repeat (4) tick();
    Flag_wb = 0;
    chk("wb_underflow", {30'd0, Pending}, 0);

    // NV always annuls and never waits
    issue(4'hF, 1);
    chk("nv_pass", {31'd0, Out_pass}, 0);
    chk("nv_pend", {30'd0, Pending}, 0);

    // Stall holds a passed decision
    issue(4'hE, 0);
    pc_before = m_pcnt;
    Stall = 1; In_valid = 1; In_cond = 4'hE;
    repeat (3) begin
      tick();
      chk("stall_valid", {31'd0, Out_valid}, 1);
      chk("stall_pass", {31'd0, Out_pass}, 1);
    end
    chk("stall_pcnt_model", m_pcnt, pc_before);
    idle();

    // Async reset mid-run with Pending=2
    issue(4'hE, 1);
    issue(4'hE, 1);
    chk("pre_rst_pend", {30'd0, Pending}, 2);
    Reset_n = 0;
    #1;
    chk("arst_valid", {31'd0, Out_valid}, 0);
    chk("arst_pass", {31'd0, Out_pass}, 0);
    chk("arst_pend", {30'd0, Pending}, 0);
    model_reset();
    @(posedge Clk);
    #1 Reset_n = 1;
    Z = 1; Fwd_valid = 1; Fwd_Z = 0;
    issue(4'h0, 0);
    chk("post_rst_psr", {31'd0, Out_pass}, 1);
    idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      In_valid  = ($urandom_range(0, 3) != 0);
      In_cond   = 4'($urandom_range(0, 15));
      In_s      = $urandom_range(0, 1);
      {N, Z, C, V} = 4'($urandom);
      Fwd_valid = $urandom_range(0, 1);
      {Fwd_N, Fwd_Z, Fwd_C, Fwd_V} = 4'($urandom);
      Flag_wb   = ($urandom_range(0, 3) == 0);
      Stall     = ($urandom_range(0, 6) == 0);
      tick();
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cond_check_stage.md
Name: cond_check_stage

Overview:
- Consumer side of the status-flag path: reads N/Z/C/V from the PSR, or forwarded flags from the ALU, and evaluates the 4-bit ARM condition field of the instruction in decode.
- Tracks flag-setting instructions still in flight and holds back condition-dependent instructions until their flags are valid.
- Registers a pass/annul decision for the execute stage.
- Sits between the decode latch and the execute-stage control mux.

Parameters:
- MAX_PENDING, 3, maximum flag-setting instructions in flight ahead of PSR write-back.
- PEND_W, 2, width of the pending counter; must hold MAX_PENDING.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- Clk  in  1  rising-edge clock
- Reset_n  in  1  asynchronous active-low reset
- In_valid  in  1  decode presents an instruction
- In_ready  out  1  instruction accepted this cycle when In_valid & In_ready
- In_cond  in  4  ARM condition field, bits 31:28
- In_s  in  1  instruction sets flags (S bit)
- N, Z, C, V  in  1 each  current PSR outputs
- Fwd_valid  in  1  ALU is producing flags this cycle
- Fwd_N, Fwd_Z, Fwd_C, Fwd_V  in  1 each  forwarded ALU flags
- Flag_wb  in  1  PSR load pulse; one flag-setting instruction retires
- Stall  in  1  downstream stall; freezes the output register
- Out_valid  out  1  registered instruction valid
- Out_pass  out  1  condition true; execute-stage writes enabled
- Out_s  out  1  registered In_s of a passed instruction
- Pending  out  PEND_W  flag-setting instructions in flight

Behaviour:
- Reset (async, Reset_n=0): Out_valid=0, Out_pass=0, Out_s=0, Pending=0. Takes effect mid-operation; any in-flight decision is discarded.
- Condition table (flags F): 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
- Flag source F: Fwd_* when Pending==1 and Fwd_valid; otherwise PSR N/Z/C/V.
- flag_hazard = Pending!=0, In_cond not 1110/1111, and not (Pending==1 & Fwd_valid).
- full = Pending==MAX_PENDING and In_s.
- In_ready = !Stall & !flag_hazard & !full. Combinational; no dependence on In_valid.
- Output register, one-cycle latency, updates only when Stall=0:
  - Accept: Out_valid=1, Out_pass=cond(F), Out_s=In_s & cond(F).
  - Otherwise (no In_valid, or hazard/full): bubble, Out_valid=0, Out_pass=0, Out_s=0.
- Stall=1: output register and all internal state hold. Pending still reacts to Flag_wb.
- Pending counter:
  - +1 on accept with In_s & cond(F); annulled S instructions never count.
  - -1 on Flag_wb.
  - Both in the same cycle: unchanged.
  - Flag_wb at Pending==0: ignored, stays 0 (no underflow).
  - Increment is impossible at MAX_PENDING because full blocks it.
- AL and NV never wait on flags. NV always annuls.

Optional Feature:
- Macro COND_STATS_EN.
- Defined: adds outputs Pass_cnt and Annul_cnt, each CNT_W wide.
  - Count accepted instructions with Out_pass=1 and Out_pass=0 respectively.
  - Saturate at all-ones; reset to 0 asynchronously.
  - Hold while Stall=1.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan:
- Reset_n low mid-run with Pending=2 -> Out_valid=0, Out_pass=0, Pending=0 immediately; first instruction after release evaluates against PSR.
- PSR Z=1, Pending=0; issue EQ (0000) then NE (0001) -> Out_pass 1 then 0, each one cycle after accept; Pending stays 0.
- Issue ADDS (AL, In_s=1), then BEQ (0000) next cycle with Fwd_valid=1, Fwd_Z=1, PSR Z=0 -> BEQ accepted without stall, Out_pass=1 (forwarded flag used); Pending 0->1.
- Pending=2, issue GT (1100) -> In_ready=0 and bubbles until Flag_wb drops Pending to 1 with Fwd_valid=1 -> accepted, evaluated on Fwd_* flags.
- Pending=3, issue AL with In_s=1 -> In_ready=0; same cycle Flag_wb=1 -> Pending 2; next cycle accepted, Pending 3. Also Flag_wb at Pending=0 -> stays 0.
- Stall=1 for 3 cycles with Out_valid=1, Out_pass=1 -> outputs held, In_ready=0. With COND_STATS_EN, Pass_cnt increments once only.
